// File: rtl/ifetch_responder_if.sv
// Fetch-side bundle: PC request handshake, instruction memory read port and
// decode-side response handshake.
interface ifetch_responder_if #(
  parameter int unsigned DEPTH_LOG2 = 12
);
  logic                  req_valid;
  logic                  req_ready;
  logic [31:0]           req_pc;
  logic                  flush;
  logic                  im_rd;
  logic [DEPTH_LOG2-1:0] im_addr;
  logic [31:0]           im_rdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_pc;
  logic [31:0]           rsp_instr;
  logic                  rsp_exc;

  modport slave (
    input  req_valid, req_pc, flush, im_rdata, rsp_ready,
    output req_ready, im_rd, im_addr, rsp_valid, rsp_pc, rsp_instr, rsp_exc
  );

  modport master (
    output req_valid, req_pc, flush, im_rdata, rsp_ready,
    input  req_ready, im_rd, im_addr, rsp_valid, rsp_pc, rsp_instr, rsp_exc
  );
endinterface

// File: rtl/ifetch_responder.sv
// Fetch responder: accepts PC fetches, reads instruction memory (1-cycle latency)
// and returns {pc, instr, exc} in order through a 2-entry response FIFO.
module ifetch_responder #(
  parameter logic [31:0] TEXT_BASE  = 32'h0000_3000,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic                clk,
  input  logic                reset,
  ifetch_responder_if.slave   bus
);

  logic        inflight_q;
  logic        inflight_bad_q;
  logic [31:0] inflight_pc_q;

  logic [1:0][31:0] fifo_pc_q;
  logic [1:0][31:0] fifo_instr_q;
  logic [1:0]       fifo_exc_q;
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;

  logic [1:0]  occ;
  logic        rsp_valid;
  logic        pop;
  logic        push;
  logic        req_ready;
  logic        accept;
  logic        below;
  logic        bad;
  logic        im_rd;
  logic [29:0] word_off;

  always_comb begin
    occ       = count_q + {1'b0, inflight_q};
    rsp_valid = (count_q != 2'd0);
    pop       = rsp_valid & bus.rsp_ready & ~bus.flush;
    push      = inflight_q & ~bus.flush;
    // Held low during reset so nothing is launched before release.
    req_ready = reset & ~bus.flush & ((occ < 2'd2) | (rsp_valid & bus.rsp_ready));
    accept    = bus.req_valid & req_ready;
    // TEXT_BASE is word aligned, so word-granular offset covers the range check.
    word_off  = bus.req_pc[31:2] - TEXT_BASE[31:2];
    below     = (bus.req_pc < TEXT_BASE);
    bad       = (bus.req_pc[1:0] != 2'b00) | below | (word_off[29:DEPTH_LOG2] != '0);
    im_rd     = accept & ~bad;
  end

  assign bus.req_ready = req_ready;
  assign bus.im_rd     = im_rd;
  assign bus.im_addr   = im_rd ? word_off[DEPTH_LOG2-1:0] : '0;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_pc    = fifo_pc_q[rd_ptr_q];
  assign bus.rsp_instr = fifo_instr_q[rd_ptr_q];
  assign bus.rsp_exc   = fifo_exc_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q     <= 1'b0;
      inflight_bad_q <= 1'b0;
      inflight_pc_q  <= '0;
      fifo_pc_q      <= '0;
      fifo_instr_q   <= '0;
      fifo_exc_q     <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      count_q        <= 2'd0;
    end else if (bus.flush) begin
      // Dropping inflight_q discards the memory word returning next cycle.
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      inflight_q <= accept;
      if (accept) begin
        inflight_pc_q  <= bus.req_pc;
        inflight_bad_q <= bad;
      end
      if (push) begin
        fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
        fifo_instr_q[wr_ptr_q] <= inflight_bad_q ? 32'h0 : bus.im_rdata;
        fifo_exc_q[wr_ptr_q]   <= inflight_bad_q;
        wr_ptr_q               <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_ifetch_responder.sv
// Directed bench for ifetch_responder with a 1-cycle instruction memory model.
module tb_ifetch_responder;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  logic [31:0] mem [4096];

  ifetch_responder_if #(.DEPTH_LOG2(12)) bus ();

  ifetch_responder #(
    .TEXT_BASE (32'h0000_3000),
    .DEPTH_LOG2(12)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Non-read cycles return junk so a bad fetch must really zero the instruction.
  always @(posedge clk) begin
    bus.im_rdata <= bus.im_rd ? mem[bus.im_addr] : 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic single_fetch(input logic [31:0] pc, input logic exp_rd,
                              input logic [31:0] exp_addr, input logic [31:0] exp_instr,
                              input logic exp_exc);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_pc    = pc;
    @(negedge clk);
    check("sf_req_ready", bus.req_ready, 1);
    check("sf_im_rd", bus.im_rd, exp_rd);
    if (exp_rd) check("sf_im_addr", bus.im_addr, exp_addr);
    next();
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("sf_valid_early", bus.rsp_valid, 0);
    next();
    @(negedge clk);
    check("sf_valid", bus.rsp_valid, 1);
    check("sf_pc", bus.rsp_pc, pc);
    check("sf_instr", bus.rsp_instr, exp_instr);
    check("sf_exc", bus.rsp_exc, exp_exc);
    next();
    @(negedge clk);
    check("sf_valid_after", bus.rsp_valid, 0);
  endtask

  logic [31:0] seq_pc    [3];
  logic [31:0] seq_instr [3];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[0]    = 32'h2408_0001;
    mem[1]    = 32'h2409_0002;
    mem[2]    = 32'h0109_5020;
    mem[64]   = 32'hAABB_CCDD;
    mem[4095] = 32'h1234_5678;
    seq_pc    = '{32'h3000, 32'h3004, 32'h3008};
    seq_instr = '{32'h2408_0001, 32'h2409_0002, 32'h0109_5020};

    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_pc    = 32'h0;
    bus.flush     = 1'b0;
    bus.rsp_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_valid", bus.rsp_valid, 0);
    check("rst_pc", bus.rsp_pc, 0);
    check("rst_instr", bus.rsp_instr, 0);
    check("rst_exc", bus.rsp_exc, 0);
    check("rst_im_rd", bus.im_rd, 0);
    check("rst_im_addr", bus.im_addr, 0);
    next();
    reset = 1'b1;
    @(negedge clk);
    check("rel_req_ready", bus.req_ready, 1);
    check("rel_im_rd", bus.im_rd, 0);
    next();

    // Sequential fetch, one per cycle, response after the second edge
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.req_valid = (i < 3);
      bus.req_pc    = (i < 3) ? seq_pc[i] : 32'h0;
      @(negedge clk);
      check("seq_req_ready", bus.req_ready, 1);
      if (i < 3) begin
        check("seq_im_rd", bus.im_rd, 1);
        check("seq_im_addr", bus.im_addr, i);
      end
      check("seq_valid", bus.rsp_valid, (i >= 2 && i <= 4));
      if (i >= 2 && i <= 4) begin
        check("seq_pc", bus.rsp_pc, seq_pc[i-2]);
        check("seq_instr", bus.rsp_instr, seq_instr[i-2]);
        check("seq_exc", bus.rsp_exc, 0);
      end
      next();
    end

    // Back-pressure
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_pc    = 32'h3000;
    @(negedge clk);
    check("bp_ready0", bus.req_ready, 1);
    next();
    bus.req_pc = 32'h3004;
    @(negedge clk);
    check("bp_ready1", bus.req_ready, 1);
    next();
    bus.req_pc = 32'h3008;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_full_ready", bus.req_ready, 0);
      check("bp_full_im_rd", bus.im_rd, 0);
      check("bp_hold_valid", bus.rsp_valid, 1);
      check("bp_hold_pc", bus.rsp_pc, 32'h3000);
      check("bp_hold_instr", bus.rsp_instr, 32'h2408_0001);
      next();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_pop_ready", bus.req_ready, 1);
    check("bp_pop_addr", bus.im_addr, 2);
    check("bp_drain_pc0", bus.rsp_pc, 32'h3000);
    next();
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("bp_drain_v1", bus.rsp_valid, 1);
    check("bp_drain_pc1", bus.rsp_pc, 32'h3004);
    check("bp_drain_i1", bus.rsp_instr, 32'h2409_0002);
    next();
    @(negedge clk);
    check("bp_drain_v2", bus.rsp_valid, 1);
    check("bp_drain_pc2", bus.rsp_pc, 32'h3008);
    check("bp_drain_i2", bus.rsp_instr, 32'h0109_5020);
    next();
    @(negedge clk);
    check("bp_empty", bus.rsp_valid, 0);
    next();

    // Misaligned and out-of-range fetches, plus the last valid word
    single_fetch(32'h3002, 1'b0, 32'h0, 32'h0, 1'b1);
    next();
    single_fetch(32'h2ffc, 1'b0, 32'h0, 32'h0, 1'b1);
    next();
    single_fetch(32'h7000, 1'b0, 32'h0, 32'h0, 1'b1);
    next();
    single_fetch(32'h6ffc, 1'b1, 32'd4095, 32'h1234_5678, 1'b0);
    next();

    // Flush with one buffered entry and one in flight
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_pc    = 32'h3000;
    next();
    bus.req_pc = 32'h3004;
    next();
    bus.req_pc    = 32'h3008;
    bus.flush     = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("fl_req_ready", bus.req_ready, 0);
    check("fl_im_rd", bus.im_rd, 0);
    check("fl_valid_during", bus.rsp_valid, 1);
    next();
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("fl_valid_after", bus.rsp_valid, 0);
      next();
    end
    single_fetch(32'h3100, 1'b1, 32'd64, 32'hAABB_CCDD, 1'b0);
    next();

    // Reset with two entries buffered
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_pc    = 32'h3000;
    next();
    bus.req_pc = 32'h3004;
    next();
    bus.req_valid = 1'b0;
    next();
    @(negedge clk);
    check("mr_valid_pre", bus.rsp_valid, 1);
    reset = 1'b0;
    #1;
    check("mr_valid", bus.rsp_valid, 0);
    check("mr_pc", bus.rsp_pc, 0);
    check("mr_instr", bus.rsp_instr, 0);
    check("mr_exc", bus.rsp_exc, 0);
    next();
    reset         = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("mr_req_ready", bus.req_ready, 1);
    check("mr_im_rd", bus.im_rd, 0);
    for (int i = 0; i < 3; i++) begin
      next();
      @(negedge clk);
      check("mr_no_stale", bus.rsp_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
